mhp_tx_framer: RTL and testbench

MHP_TX_FRAMER -- requirements
Module: mhp_tx_framer

---
 rtl/mhp_tx_framer.sv | 188 ++++++++++++++++++
 tb/tb_mhp_tx_framer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mhp_tx_framer.sv
// MHP transmit framer: cuts a task payload from a FWFT FIFO into MHP packets, one header per segment.
// Build macro MHP_TX_PINGPONG_EN: header bit 0 toggles after every fully sent segment (default: constant 0).
module mhp_tx_framer #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_SEG_LOG2 = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [15:0]           i_task_len,
    input  logic [7:0]            i_task_number,
    input  logic [23:0]           i_cfg,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_underrun,
    input  logic [DATA_WIDTH-1:0] i_pl_data,
    input  logic                  i_pl_empty,
    output logic                  o_pl_rd,
    output logic [63:0]           o_mhp_tx_header,
    output logic                  o_mhp_tx_valid,
    output logic [DATA_WIDTH-1:0] o_mhp_tx_data,
    input  logic                  i_mhp_tx_data_ack,
    input  logic                  i_mhp_tx_busy,
    input  logic                  i_mhp_header_sent
);
    localparam logic [10:0] SEG_BYTES = 11'(1 << MAX_SEG_LOG2);
    localparam logic [16:0] SEG_ROUND = 17'((1 << MAX_SEG_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, CHECK, WAIT_READY, HEADER, PAYLOAD, GAP} state_t;

    state_t      state_q;
    logic [15:0] len_q;
    logic [7:0]  task_q;
    logic [23:0] cfg_q;
    logic [7:0]  nseg_q;
    logic [7:0]  seg_idx_q;
    logic [10:0] last_size_q;
    logic [10:0] cnt_q;
    logic        gap_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        underrun_q;
    logic        valid_q;
    logic [63:0] header_q;

    logic [16:0] nseg_d;
    logic [10:0] last_size_d;
    logic [10:0] first_size_d;
    logic [7:0]  next_idx_d;
    logic [10:0] next_size_d;
    logic [10:0] cnt_d;
    logic        pop_d;
    logic        seg_last_d;
    logic        pp_bit;

    function automatic logic [63:0] make_header(input logic [23:0] cfg, input logic [7:0] nseg,
                                                input logic [7:0] idx, input logic [7:0] task_num,
                                                input logic [10:0] size, input logic pp);
        return {cfg, nseg, idx, task_num, size, 4'b0000, pp};
    endfunction

    // Segment count in 17 bits so a 16-bit length plus rounding cannot wrap.
    assign nseg_d       = ({1'b0, len_q} + SEG_ROUND) >> MAX_SEG_LOG2;
    assign last_size_d  = (len_q[MAX_SEG_LOG2-1:0] == '0) ? SEG_BYTES : 11'(len_q[MAX_SEG_LOG2-1:0]);
    assign first_size_d = (nseg_d == 17'd1) ? last_size_d : SEG_BYTES;
    assign next_idx_d   = seg_idx_q + 8'd1;
    assign next_size_d  = (next_idx_d == nseg_q - 8'd1) ? last_size_q : SEG_BYTES;
    assign cnt_d        = cnt_q + 11'd1;
    assign pop_d        = (state_q == PAYLOAD) && i_mhp_tx_data_ack && !i_pl_empty;
    assign seg_last_d   = pop_d && (cnt_d == header_q[15:5]);

    // NOTE: the pop must be combinational so the FWFT head advances in the same cycle the byte is acked.
    assign o_pl_rd         = pop_d && !i_rst;
    assign o_mhp_tx_data   = i_pl_data;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_underrun      = underrun_q;
    assign o_mhp_tx_valid  = valid_q;
    assign o_mhp_tx_header = header_q;

`ifdef MHP_TX_PINGPONG_EN
    logic pp_q;
    assign pp_bit = pp_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pp_q <= 1'b0;
        end else if (seg_last_d) begin
            pp_q <= ~pp_q;
        end
    end
`else
    assign pp_bit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            task_q      <= '0;
            cfg_q       <= '0;
            nseg_q      <= '0;
            seg_idx_q   <= '0;
            last_size_q <= '0;
            cnt_q       <= '0;
            gap_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            underrun_q  <= 1'b0;
            valid_q     <= 1'b0;
            header_q    <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        len_q   <= i_task_len;
                        task_q  <= i_task_number;
                        cfg_q   <= i_cfg;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (len_q == 16'd0 || nseg_d > 17'd255) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        nseg_q      <= nseg_d[7:0];
                        last_size_q <= last_size_d;
                        seg_idx_q   <= 8'd0;
                        header_q    <= make_header(cfg_q, nseg_d[7:0], 8'd0, task_q, first_size_d, pp_bit);
                        state_q     <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (!i_mhp_tx_busy && !i_pl_empty) begin
                        valid_q <= 1'b1;
                        state_q <= HEADER;
                    end
                end
                HEADER: begin
                    if (i_mhp_header_sent) begin
                        cnt_q   <= 11'd0;
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (i_mhp_tx_data_ack && i_pl_empty) begin
                        underrun_q <= 1'b1;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (pop_d) begin
                        cnt_q <= cnt_d;
                        if (seg_last_d) begin
                            valid_q <= 1'b0;
                            gap_q   <= 1'b0;
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (!gap_q) begin
                        gap_q <= 1'b1;
                    end else if (next_idx_d == nseg_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        seg_idx_q <= next_idx_d;
                        header_q  <= make_header(cfg_q, nseg_q, next_idx_d, task_q, next_size_d, pp_bit);
                        state_q   <= WAIT_READY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mhp_tx_framer.sv
// Self-checking bench for mhp_tx_framer (MAX_SEG_LOG2=4): vector table, corner sequences, random tasks vs model.
module tb_mhp_tx_framer;
    localparam int SEG = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] task_len;
    logic [7:0]  task_number;
    logic [23:0] cfg_in;
    logic        busy, done, err, underrun;
    logic [7:0]  pl_data;
    logic        pl_empty;
    logic        pl_rd;
    logic [63:0] header;
    logic        valid;
    logic [7:0]  tx_data;
    logic        ack, mhp_busy, hdr_sent;
    logic        force_empty;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_ptr   = 0;
    int rd_ptr   = 0;
    int data_bad = 0;
    int pp_count = 0;

    always #5 clk = ~clk;

    mhp_tx_framer #(.DATA_WIDTH(8), .MAX_SEG_LOG2(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_task_len(task_len),
        .i_task_number(task_number), .i_cfg(cfg_in), .o_busy(busy), .o_done(done),
        .o_err(err), .o_underrun(underrun), .i_pl_data(pl_data), .i_pl_empty(pl_empty),
        .o_pl_rd(pl_rd), .o_mhp_tx_header(header), .o_mhp_tx_valid(valid),
        .o_mhp_tx_data(tx_data), .i_mhp_tx_data_ack(ack), .i_mhp_tx_busy(mhp_busy),
        .i_mhp_header_sent(hdr_sent)
    );

    // FIFO model: byte at stream position n is pattern(n); the bench writes by advancing wr_ptr.
    function automatic logic [7:0] pattern(input int idx);
        return 8'((idx * 37 + 11) & 255);
    endfunction

    assign pl_empty = force_empty || (rd_ptr == wr_ptr);
    assign pl_data  = pattern(rd_ptr);

    always @(posedge clk) begin
        if (pl_rd) begin
            if (tx_data !== pattern(rd_ptr) || pl_empty) data_bad <= data_bad + 1;
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; ack = 1'b0; hdr_sent = 1'b0; mhp_busy = 1'b0; force_empty = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_valid", 64'(valid), 0);
        check("rst_pulses", 64'({done, err, underrun}), 0);
        check("rst_pl_rd", 64'(pl_rd), 0);
        check("rst_header", header, 0);
        rst = 1'b0;
        pp_count = 0;
    endtask

    // Drives one task and plays the MHP engine with random handshakes; compares against the segment model.
    task automatic run_task(input int len, input logic [7:0] tnum, input logic [23:0] cfg,
                            input bit tbl_err, input int tbl_npkt, input int tbl_last);
        int nseg, budget, cyc, n_done, n_err, n_und, rise_ptr, bad0, hdr_moves, size;
        bit merr, prev_valid, hs_done, spurious_done, pp_exp;
        logic [63:0] hdrs[$];
        int sizes[$];
        logic [63:0] cur_hdr, exp_hdr;
        nseg = (len + SEG - 1) / SEG;
        merr = (len == 0) || (nseg > 255);
        budget = 200 + 4 * len;
        if (!merr) wr_ptr += len;
        bad0 = data_bad;
        n_done = 0; n_err = 0; n_und = 0; hdr_moves = 0; rise_ptr = rd_ptr;
        prev_valid = 1'b0; hs_done = 1'b0; spurious_done = 1'b0; cur_hdr = '0;
        @(negedge clk);
        task_len = 16'(len); task_number = tnum; cfg_in = cfg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 1);
        cyc = 0;
        while (cyc < budget) begin
            if (done) n_done++;
            if (err) n_err++;
            if (underrun) n_und++;
            if (valid && !prev_valid) begin
                cur_hdr = header;
                hdrs.push_back(header);
                rise_ptr = rd_ptr;
            end
            if (valid && header !== cur_hdr) hdr_moves++;
            if (!valid && prev_valid) sizes.push_back(rd_ptr - rise_ptr);
            prev_valid = valid;
            if (!busy) break;
            mhp_busy = ($urandom_range(0, 3) == 0);
            if (!valid) hs_done = 1'b0;
            if (valid && !hs_done && $urandom_range(0, 1) == 1) begin
                hdr_sent = 1'b1;
                hs_done  = 1'b1;
            end else begin
                hdr_sent = 1'b0;
            end
            ack = ($urandom_range(0, 3) != 0);
            if (valid && !spurious_done) begin
                start = 1'b1; task_len = 16'hFFFF; spurious_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        ack = 1'b0; hdr_sent = 1'b0; start = 1'b0; mhp_busy = 1'b0;
        check("task_finished", 64'(cyc < budget), 1);
        check("err_pulse", 64'(n_err), 64'(merr));
        check("done_pulse", 64'(n_done), 64'(!merr));
        check("no_underrun", 64'(n_und), 0);
        check("packet_count", 64'(hdrs.size()), merr ? 0 : 64'(nseg));
        if (tbl_npkt >= 0) begin
            check("tbl_err", 64'(n_err), 64'(tbl_err));
            check("tbl_packet_count", 64'(hdrs.size()), 64'(tbl_npkt));
            if (sizes.size() > 0) check("tbl_last_size", 64'(sizes[sizes.size()-1]), 64'(tbl_last));
        end
        for (int i = 0; i < hdrs.size() && i < nseg; i++) begin
            size = (len - i * SEG < SEG) ? len - i * SEG : SEG;
`ifdef MHP_TX_PINGPONG_EN
            pp_exp = 1'((pp_count + i) & 1);
`else
            pp_exp = 1'b0;
`endif
            exp_hdr = {cfg, 8'(nseg), 8'(i), tnum, 11'(size), 4'b0000, pp_exp};
            check($sformatf("header[%0d]", i), hdrs[i], exp_hdr);
            if (i < sizes.size()) check($sformatf("pops[%0d]", i), 64'(sizes[i]), 64'(size));
        end
        check("header_stable", 64'(hdr_moves), 0);
        check("payload_data", 64'(data_bad - bad0), 0);
        @(negedge clk);
        check("pulse_width", 64'({done, err}), 0);
        if (!merr) pp_count += nseg;
        if (cyc >= budget) do_reset();
    endtask

    typedef struct {
        int          len;
        logic [7:0]  tnum;
        logic [23:0] cfg;
        bit          exp_err;
        int          npkt;
        int          last;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, c;
        rst = 1'b1; start = 1'b0; task_len = '0; task_number = '0; cfg_in = '0;
        ack = 1'b0; mhp_busy = 1'b0; hdr_sent = 1'b0; force_empty = 1'b0;
        do_reset();

        vecs[0] = '{40,   8'd5,  24'hE3_BEEF, 1'b0, 3,   8};
        vecs[1] = '{0,    8'd6,  24'h12_3456, 1'b1, 0,   0};
        vecs[2] = '{4081, 8'd7,  24'h7F_0001, 1'b1, 0,   0};
        vecs[3] = '{4080, 8'd8,  24'h81_8000, 1'b0, 255, 16};
        vecs[4] = '{16,   8'd9,  24'h40_AAAA, 1'b0, 1,   16};
        vecs[5] = '{1,    8'd10, 24'h05_5555, 1'b0, 1,   1};
        vecs[6] = '{17,   8'd11, 24'hFF_FFFF, 1'b0, 2,   1};
        vecs[7] = '{33,   8'd12, 24'h00_0000, 1'b0, 3,   1};
        for (int v = 0; v < 8; v++)
            run_task(vecs[v].len, vecs[v].tnum, vecs[v].cfg, vecs[v].exp_err, vecs[v].npkt, vecs[v].last);

        // Underrun: FIFO reports empty on the 6th ack of a 16-byte segment.
        wr_ptr += 16;
        @(negedge clk);
        task_len = 16'd16; task_number = 8'd20; cfg_in = 24'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!valid && c < 50) begin @(negedge clk); c++; end
        check("und_valid_up", 64'(valid), 1);
        hdr_sent = 1'b1;
        @(negedge clk);
        hdr_sent = 1'b0;
        p0 = rd_ptr;
        ack = 1'b1;
        repeat (5) @(negedge clk);
        force_empty = 1'b1;
        #1;
        check("und_no_pop_when_empty", 64'(pl_rd), 0);
        @(negedge clk);
        check("und_pulse", 64'(underrun), 1);
        check("und_valid_low", 64'(valid), 0);
        check("und_busy_low", 64'(busy), 0);
        check("und_pop_count", 64'(rd_ptr - p0), 5);
        ack = 1'b0; force_empty = 1'b0;
        @(negedge clk);
        check("und_pulse_width", 64'(underrun), 0);

        // Reset in the middle of a payload, with ack still asserted.
        wr_ptr += 40;
        task_len = 16'd40; task_number = 8'd21; cfg_in = 24'h2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!valid && c < 50) begin @(negedge clk); c++; end
        check("rstp_valid_up", 64'(valid), 1);
        hdr_sent = 1'b1;
        @(negedge clk);
        hdr_sent = 1'b0; ack = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstp_valid", 64'(valid), 0);
        check("rstp_busy", 64'(busy), 0);
        check("rstp_pl_rd", 64'(pl_rd), 0);
        rst = 1'b0; ack = 1'b0; pp_count = 0;
        run_task(20, 8'd22, 24'hC0_FFEE, 1'b0, 2, 4);

        for (int r = 0; r < 12; r++)
            run_task(int'($urandom_range(1, 200)), 8'($urandom), 24'($urandom), 1'b0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
